// File: rtl/second_timer_ctrl.sv
// Seconds-counter control: prescaler dividing clk to a TICK_CYCLES-period tick,
// plus an IDLE/RUN/PAUSE/DONE sequencer for an up/down time count.
module second_timer_ctrl #(
    parameter int unsigned TICK_CYCLES = 100000000,
    parameter int unsigned TIME_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              clear,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              count_down,
    output logic [TIME_W-1:0] Time,
    output logic              tick,
    output logic              expired,
    output logic              running,
    output logic [1:0]        state
);

    localparam int unsigned PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              dir_q, dir_d;
    logic              tick_q, tick_d;
    logic              expired_q, expired_d;
    logic              running_q, running_d;
    logic              can_start;
    logic              wrap;

    // A countdown from zero would immediately underflow, so the direction
    // being latched (count_down) blocks the start when Time is already 0.
    assign can_start = start && !(count_down && (time_q == '0));
    assign wrap      = (presc_q == PRESC_MAX);

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        presc_d   = presc_q;
        dir_d     = dir_q;
        tick_d    = 1'b0;
        expired_d = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            time_d  = '0;
            presc_d = '0;
        end else if (load && (state_q != S_RUN)) begin
            state_d = S_IDLE;
            time_d  = load_val;
            presc_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_PAUSE: begin
                    // PAUSE keeps presc_q so a resume finishes the partial second
                    if (can_start) begin
                        state_d = S_RUN;
                        dir_d   = count_down;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else if (wrap) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (dir_q) begin
                            time_d = time_q - TIME_W'(1);
                            if (time_q == TIME_W'(1)) begin
                                state_d   = S_DONE;
                                expired_d = 1'b1;
                            end
                        end else begin
                            time_d = time_q + TIME_W'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: ;
            endcase
        end

        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            time_q    <= '0;
            presc_q   <= '0;
            dir_q     <= 1'b0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            presc_q   <= presc_d;
            dir_q     <= dir_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
            running_q <= running_d;
        end
    end

    assign Time    = time_q;
    assign tick    = tick_q;
    assign expired = expired_q;
    assign running = running_q;
    assign state   = state_q;

endmodule
